mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Scan sequencer for an external 8:1 mux. It walks the select lines through
// channels 0..7. It waits SETTLE_CYCLES idle cycles on each channel and then
// captures mux_in. The eight samples form one byte, which is handed downstream
// on a valid/ready handshake. A scan can run once or repeat continuously.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request one scan (only looked at in IDLE)
//   continuous  restart scanning automatically after each word handshake
//   mux_in      selected data bit from the mux
//   sel         mux select {S2,S1,S0}
//   word_data   assembled word, bit k = sample of channel k
//   word_valid  word_data valid
//   word_ready  downstream accepts word
//   busy        high while scanning or holding a word
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       mux_in,
  output logic [2:0] sel,
  output logic [7:0] word_data,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OUT
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] cap, cap_n;
  logic [7:0] data_n;
  logic [2:0] sel_n;
  logic       valid_n;

  // Next-state logic. Every output is computed here and then registered,
  // so sel, word_data and word_valid change only on clock edges.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_n   = cap;
    sel_n   = sel;
    data_n  = word_data;
    valid_n = word_valid;
    case (state)
      IDLE: begin
        sel_n = 3'd0;
        if (start) begin
          state_n = SCAN;
          cnt_n   = 4'd0;
          cap_n   = 8'h00;
        end
      end
      SCAN: begin
        if (cnt < SETTLE) begin
          cnt_n = cnt + 4'd1;
        end else begin
          // Capture edge. mux_in is sampled only here, so any glitches
          // during the settle cycles are ignored.
          cnt_n      = 4'd0;
          cap_n[sel] = mux_in;
          if (sel != 3'd7) begin
            sel_n = sel + 3'd1;
          end else begin
            // The last channel is folded in using the bit captured on this same edge.
            data_n  = cap_n;
            sel_n   = 3'd0;
            valid_n = 1'b1;
            state_n = OUT;
          end
        end
      end
      OUT: begin
        // The scan stays paused here, so no sample can be lost while a
        // word is still waiting for the handshake.
        if (word_ready) begin
          valid_n = 1'b0;
          sel_n   = 3'd0;
          cnt_n   = 4'd0;
          cap_n   = 8'h00;
          state_n = continuous ? SCAN : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = 3'd0;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers. A reset discards any partial or pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap        <= 8'h00;
      sel        <= 3'd0;
      word_data  <= 8'h00;
      word_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cap        <= cap_n;
      sel        <= sel_n;
      word_data  <= data_n;
      word_valid <= valid_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed testbench for mux_scan_ctrl. It builds three instances with
// SETTLE_CYCLES set to 1, 3 and 0. Each instance has its own behavioural mux
// model driven from a bench-held data byte.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance with SETTLE_CYCLES=1
  logic       start1, cont1, ready1, mux1, valid1, busy1;
  logic [2:0] sel1;
  logic [7:0] data1, d1;
  // instance with SETTLE_CYCLES=3
  logic       start3, cont3, ready3, mux3, valid3, busy3, filt3;
  logic [2:0] sel3;
  logic [7:0] data3, d3;
  // instance with SETTLE_CYCLES=0
  logic       start0, cont0, ready0, mux0, valid0, busy0;
  logic [2:0] sel0;
  logic [7:0] data0, d0;

  assign mux1 = d1[sel1];
  assign mux3 = filt3 ? ~d3[sel3] : d3[sel3];
  assign mux0 = d0[sel0];

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .continuous(cont1), .mux_in(mux1),
    .sel(sel1), .word_data(data1), .word_valid(valid1), .word_ready(ready1), .busy(busy1)
  );
  mux_scan_ctrl #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .continuous(cont3), .mux_in(mux3),
    .sel(sel3), .word_data(data3), .word_valid(valid3), .word_ready(ready3), .busy(busy3)
  );
  mux_scan_ctrl #(.SETTLE_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .continuous(cont0), .mux_in(mux0),
    .sel(sel0), .word_data(data0), .word_valid(valid0), .word_ready(ready0), .busy(busy0)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 0; cont1 = 0; ready1 = 0; d1 = 8'h00;
    start3 = 0; cont3 = 0; ready3 = 0; d3 = 8'h00; filt3 = 0;
    start0 = 0; cont0 = 0; ready0 = 0; d0 = 8'h00;
    #12;
    checks++; if (sel1 !== 3'd0) begin errors++; $display("[TB] FAIL reset_sel got %0d exp 0", sel1); end
    checks++; if (data1 !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h exp 00", data1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", valid1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy1); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_scan();
    logic [2:0] exp_sel;
    d1 = 8'hA5; ready1 = 1'b1; cont1 = 1'b0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      exp_sel = (n < 16) ? 3'(n / 2) : 3'd0;
      checks++; if (sel1 !== exp_sel) begin errors++; $display("[TB] FAIL single_sel cyc %0d got %0d exp %0d", n, sel1, exp_sel); end
      checks++; if (valid1 !== (n == 16)) begin errors++; $display("[TB] FAIL single_valid cyc %0d got %b exp %b", n, valid1, (n == 16)); end
    end
    checks++; if (data1 !== 8'hA5) begin errors++; $display("[TB] FAIL single_data got %h exp a5", data1); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b exp 1", busy1); end
    @(posedge clk); #1;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_drop got %b exp 0", valid1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy got %b exp 0", busy1); end
  endtask

  task automatic test_backpressure();
    int lat;
    d1 = 8'h5A; ready1 = 1'b0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    lat = 0;
    while (!valid1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 16) begin errors++; $display("[TB] FAIL bp_latency got %0d exp 16", lat); end
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      checks++; if (valid1 !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid cyc %0d got %b exp 1", n, valid1); end
      checks++; if (data1 !== 8'h5A) begin errors++; $display("[TB] FAIL bp_data cyc %0d got %h exp 5a", n, data1); end
      checks++; if (sel1 !== 3'd0) begin errors++; $display("[TB] FAIL bp_sel cyc %0d got %0d exp 0", n, sel1); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy cyc %0d got %b exp 1", n, busy1); end
    end
    ready1 = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL bp_handshake_valid got %b exp 0", valid1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL bp_handshake_busy got %b exp 0", busy1); end
    checks++; if (data1 !== 8'h5A) begin errors++; $display("[TB] FAIL bp_data_hold got %h exp 5a", data1); end
  endtask

  task automatic test_reset_midscan();
    int lat;
    d1 = 8'h96; ready1 = 1'b1;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    lat = 0;
    while (sel1 != 3'd4 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (sel1 !== 3'd4) begin errors++; $display("[TB] FAIL rst_reach_sel4 got %0d exp 4", sel1); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (sel1 !== 3'd0) begin errors++; $display("[TB] FAIL rst_mid_sel got %0d exp 0", sel1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %b exp 0", valid1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b exp 0", busy1); end
    checks++; if (data1 !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_data got %h exp 00", data1); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    lat = 0;
    while (!valid1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 16) begin errors++; $display("[TB] FAIL rst_rescan_latency got %0d exp 16", lat); end
    checks++; if (data1 !== 8'h96) begin errors++; $display("[TB] FAIL rst_rescan_data got %h exp 96", data1); end
    @(posedge clk); #1;
  endtask

  task automatic test_continuous();
    int lat;
    d1 = 8'h3C; ready1 = 1'b1; cont1 = 1'b1;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    lat = 0;
    while (!valid1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 16) begin errors++; $display("[TB] FAIL cont_lat1 got %0d exp 16", lat); end
    checks++; if (data1 !== 8'h3C) begin errors++; $display("[TB] FAIL cont_word1 got %h exp 3c", data1); end
    d1 = 8'hC3;
    @(posedge clk); #1;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL cont_hs_valid got %b exp 0", valid1); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL cont_rescan_busy got %b exp 1", busy1); end
    checks++; if (sel1 !== 3'd0) begin errors++; $display("[TB] FAIL cont_rescan_sel got %0d exp 0", sel1); end
    lat = 0;
    while (!valid1 && lat < 40) begin
      start1 = (lat == 3 || lat == 9);
      if (lat == 5) cont1 = 1'b0;
      @(posedge clk); #1; lat++;
    end
    start1 = 1'b0;
    checks++; if (lat !== 16) begin errors++; $display("[TB] FAIL cont_lat2 got %0d exp 16", lat); end
    checks++; if (data1 !== 8'hC3) begin errors++; $display("[TB] FAIL cont_word2 got %h exp c3", data1); end
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL cont_stop_busy got %b exp 0", busy1); end
  endtask

  task automatic test_settle_filter();
    logic [2:0] exp_sel;
    d3 = 8'hF0; ready3 = 1'b1;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    filt3 = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk); #1;
      exp_sel = (n < 32) ? 3'(n / 4) : 3'd0;
      checks++; if (sel3 !== exp_sel) begin errors++; $display("[TB] FAIL settle3_sel cyc %0d got %0d exp %0d", n, sel3, exp_sel); end
      checks++; if (valid3 !== (n == 32)) begin errors++; $display("[TB] FAIL settle3_valid cyc %0d got %b exp %b", n, valid3, (n == 32)); end
      filt3 = ((n + 1) % 4) != 0;
    end
    filt3 = 1'b0;
    checks++; if (data3 !== 8'hF0) begin errors++; $display("[TB] FAIL settle3_data got %h exp f0", data3); end
    @(posedge clk); #1;
  endtask

  task automatic test_settle_zero();
    logic [2:0] exp_sel;
    d0 = 8'h81; ready0 = 1'b1;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      exp_sel = (n < 8) ? 3'(n) : 3'd0;
      checks++; if (sel0 !== exp_sel) begin errors++; $display("[TB] FAIL settle0_sel cyc %0d got %0d exp %0d", n, sel0, exp_sel); end
      checks++; if (valid0 !== (n == 8)) begin errors++; $display("[TB] FAIL settle0_valid cyc %0d got %b exp %b", n, valid0, (n == 8)); end
    end
    checks++; if (data0 !== 8'h81) begin errors++; $display("[TB] FAIL settle0_data got %h exp 81", data0); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_backpressure();
    test_reset_midscan();
    test_continuous();
    test_settle_filter();
    test_settle_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
